prbs8_checker: RTL and testbench
================================

Name: prbs8_checker

Overview:
- Receive-side counterpart of the team's 8-bit LFSR pattern generator.
- Consumes the generator's serial output bit (the LSB of its state, one bit per shift) and self-synchronises to the sequence.
- Once synchronised, checks every further bit and counts bit errors.
- Sits at the far end of a serial test link, or in a loopback bench, to qualify the link.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions in HUNT needed to declare lock (range 1..255).
- LOSS_THR, 4: errors within one LOSS_WIN bit window that force loss of lock (range 1..LOSS_WIN).
- LOSS_WIN, 32: length in valid bits of the loss-detection window (range 2..255).
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  din is valid this cycle; nothing advances when low.
- din  in  1  received serial bit.
- clr  in  1  synchronous clear of err_cnt and the optional bit counter; does not affect lock state.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse, asserted the cycle after a valid bit mismatches in LOCKED.
- err_cnt  out  ERR_W  saturating count of mismatches in LOCKED.
- state  out  2  FILL=0, HUNT=1, LOCKED=2.

Behaviour:
- Reset (rst low, asynchronous): state=FILL, window=0, fill count=0, match count=0, loss counters=0, locked=0, err=0, err_cnt=0.
- Window w[7:0]: w[0] is the oldest bit.
  - pred = w[4]^w[3]^w[2]^w[0].
  - Shift is w <= {new, w[7:1]}, which matches the generator recurrence b(n+8) = b(n+4)^b(n+3)^b(n+2)^b(n).
- All state updates happen only on cycles with en=1. err is forced to 0 on every cycle with en=0.
- FILL:
  - Each valid bit shifts din into w and increments the fill count.
  - After the 8th bit, go to HUNT with match count=0.
- HUNT:
  - Each valid bit compares din with pred, then shifts din into w (self-sync).
  - Match: match count +1. Mismatch: match count=0.
  - A match is not counted if the new w would be 8'h00, because the all-zero stream is the LFSR lockup state.
  - When match count reaches LOCK_CNT: go to LOCKED and clear the loss counters.
  - No err pulses and no err_cnt changes in HUNT.
- LOCKED (flywheel):
  - w shifts in pred, not din, so a line error does not corrupt the reference.
  - Mismatch (din != pred): err=1 next cycle; err_cnt +1, saturating at all-ones; window error count +1.
  - Window bit count increments per valid bit. When it reaches LOSS_WIN, both window counters reset to 0.
  - When the window error count reaches LOSS_THR: go to FILL on the same edge. Clear fill count and match count; w is kept but refilled.
- Timing: locked and state are registered. locked rises on the edge that consumes the LOCK_CNT-th matching bit.
- clr and an error in the same cycle: clr wins, so err_cnt=0. err still pulses.
- Reset mid-operation: everything returns to reset values immediately; err_cnt is lost.

Optional Feature:
- Macro PRBS8_CHECKER_BITCNT_EN.
- Defined:
  - Adds output bit_cnt (32 bits, reset 0).
  - Counts valid bits consumed while in LOCKED, saturating at 32'hFFFF_FFFF.
  - Cleared by clr.
  - Allows a bench or host to compute BER as err_cnt/bit_cnt.
- Not defined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Generator seeded 8'hA5, en=1 continuously, default parameters -> state FILL for 8 bits, HUNT for 16; locked=1 after the 24th bit edge; err_cnt=0 after 1000 bits.
- Locked; flip 1 bit at bit 100 -> exactly one err pulse one cycle later; err_cnt=1; locked stays 1 (flywheel, no error cascade).
- Locked; flip 4 bits within 32 bits -> state=FILL on the 4th error; relocks 24 bits later; err_cnt=4.
- din held 0, en=1, for 100 bits -> never leaves HUNT; locked=0; err_cnt=0.
- en toggled 1/0 every cycle with the same stream -> lock after 24 valid bits (47 cycles); err stays 0 during en=0 cycles.
- Locked with err_cnt=3; clr asserted in the same cycle as an error -> err_cnt=0, err=1. Separately, rst low mid-stream -> all outputs 0 at once. With PRBS8_CHECKER_BITCNT_EN defined: bit_cnt=976 after 1000 clean bits.

Source files
------------

// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - self-synchronising checker for the 8-bit LFSR pattern stream
//
// Purpose: fills an 8-bit window from the received serial bit and hunts for
// LOCK_CNT consecutive correct predictions. Once locked it flywheels on its own
// prediction, counts mismatches in err_cnt, and drops back to FILL when
// LOSS_THR errors land inside one LOSS_WIN-bit window.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   en       in   din valid this cycle; all state holds when low
//   din      in   received serial bit (generator state LSB)
//   clr      in   synchronous clear of err_cnt (and bit_cnt); lock state untouched
//   locked   out  high while in LOCKED
//   err      out  one-cycle pulse the cycle after a valid mismatch in LOCKED
//   err_cnt  out  saturating mismatch count (ERR_W bits)
//   state    out  FILL=0, HUNT=1, LOCKED=2
//   bit_cnt  out  saturating count of valid bits seen in LOCKED
//                 (present only with PRBS8_CHECKER_BITCNT_EN defined)
//
// Build option: PRBS8_CHECKER_BITCNT_EN adds bit_cnt.

module prbs8_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_THR = 4,
  parameter int LOSS_WIN = 32,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
`ifdef PRBS8_CHECKER_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] THR_C  = 8'(LOSS_THR);
  localparam logic [7:0] WIN_C  = 8'(LOSS_WIN);

  state_e           state_q, state_d;
  logic [7:0]       w_q, w_d;
  logic [3:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       wbits_q, wbits_d;
  logic [7:0]       werr_q, werr_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`ifdef PRBS8_CHECKER_BITCNT_EN
  logic [31:0]      bit_cnt_q, bit_cnt_d;
`endif

  logic       pred;
  logic       mismatch;
  logic [7:0] w_din;
  logic [7:0] w_pred;
  logic [7:0] werr_inc;
  logic [7:0] wbits_inc;

  // w[0] is the oldest bit; the recurrence predicts the bit entering at w[7].
  assign pred      = w_q[4] ^ w_q[3] ^ w_q[2] ^ w_q[0];
  assign mismatch  = din ^ pred;
  assign w_din     = {din, w_q[7:1]};
  assign w_pred    = {pred, w_q[7:1]};
  assign werr_inc  = werr_q + {7'd0, mismatch};
  assign wbits_inc = wbits_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    fill_d    = fill_q;
    match_d   = match_q;
    wbits_d   = wbits_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
`ifdef PRBS8_CHECKER_BITCNT_EN
    bit_cnt_d = bit_cnt_q;
`endif

    if (en) begin
      case (state_q)
        ST_FILL: begin
          w_d    = w_din;
          fill_d = fill_q + 4'd1;
          if (fill_q == 4'd7) begin
            state_d = ST_HUNT;
            match_d = 8'd0;
          end
        end

        ST_HUNT: begin
          w_d = w_din;
          // An all-zero window is the LFSR lockup state, never a real
          // sequence position, so it restarts the match run.
          if (mismatch || (w_din == 8'h00)) begin
            match_d = 8'd0;
          end else begin
            match_d = match_q + 8'd1;
            if (match_q + 8'd1 == LOCK_C) begin
              state_d = ST_LOCKED;
              wbits_d = 8'd0;
              werr_d  = 8'd0;
            end
          end
        end

        ST_LOCKED: begin
          // Flywheel: the reference advances on its own prediction so a
          // line error cannot corrupt it.
          w_d = w_pred;
`ifdef PRBS8_CHECKER_BITCNT_EN
          if (bit_cnt_q != 32'hFFFF_FFFF) bit_cnt_d = bit_cnt_q + 32'd1;
`endif
          if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
          end
          if (werr_inc == THR_C) begin
            state_d = ST_FILL;
            fill_d  = 4'd0;
            match_d = 8'd0;
            wbits_d = 8'd0;
            werr_d  = 8'd0;
          end else if (wbits_inc == WIN_C) begin
            wbits_d = 8'd0;
            werr_d  = 8'd0;
          end else begin
            wbits_d = wbits_inc;
            werr_d  = werr_inc;
          end
        end

        default: begin
          state_d = ST_FILL;
          fill_d  = 4'd0;
        end
      endcase
    end

    // A host clear is honoured whether or not data is valid, and beats a
    // same-cycle error increment.
    if (clr) begin
      err_cnt_d = '0;
`ifdef PRBS8_CHECKER_BITCNT_EN
      bit_cnt_d = 32'd0;
`endif
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      w_q       <= 8'h00;
      fill_q    <= 4'd0;
      match_q   <= 8'd0;
      wbits_q   <= 8'd0;
      werr_q    <= 8'd0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
`ifdef PRBS8_CHECKER_BITCNT_EN
      bit_cnt_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      wbits_q   <= wbits_d;
      werr_q    <= werr_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
`ifdef PRBS8_CHECKER_BITCNT_EN
      bit_cnt_q <= bit_cnt_d;
`endif
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign state   = state_q;
`ifdef PRBS8_CHECKER_BITCNT_EN
  assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// tb/tb_prbs8_checker.sv - scoreboard bench for prbs8_checker

module tb_prbs8_checker;

  localparam int LOCK_CNT = 16;
  localparam int LOSS_THR = 4;
  localparam int LOSS_WIN = 32;
  localparam int ERR_W    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             din = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       state;
  logic [31:0]      bit_cnt_w;
`ifdef PRBS8_CHECKER_BITCNT_EN
  logic [31:0]      bit_cnt;
  assign bit_cnt_w = bit_cnt;
`else
  assign bit_cnt_w = 32'd0;
`endif

  prbs8_checker #(
    .LOCK_CNT(LOCK_CNT), .LOSS_THR(LOSS_THR), .LOSS_WIN(LOSS_WIN), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .state(state)
`ifdef PRBS8_CHECKER_BITCNT_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus source: the team generator ----------------
  logic [7:0] gen;
  task automatic get_bit(output logic b);
    b   = gen[0];
    gen = {gen[4] ^ gen[3] ^ gen[2] ^ gen[0], gen[7:1]};
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [1:0]  state;
    logic [31:0] bit_cnt;
  } exp_t;

  exp_t exp_q[$];

  int          m_state;   // 0 fill, 1 hunt, 2 locked
  bit          ref_q[$];  // last eight reference bits, oldest first
  int          m_fill, m_match, m_wbits, m_werr;
  logic [15:0] m_errcnt;
  logic [31:0] m_bits;

  task automatic m_reset();
    m_state = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0;
    m_errcnt = 16'd0; m_bits = 32'd0;
    ref_q.delete();
    repeat (8) ref_q.push_back(1'b0);
  endtask

  task automatic m_step(input bit e, input bit d, input bit c);
    bit   pred;
    bit   any_one;
    exp_t x;
    x.err = 1'b0;
    if (e) begin
      pred = ref_q[0] ^ ref_q[2] ^ ref_q[3] ^ ref_q[4];
      if (m_state == 2) begin
        if (m_bits != 32'hFFFF_FFFF) m_bits++;
        void'(ref_q.pop_front()); ref_q.push_back(pred);
        m_wbits++;
        if (d != pred) begin
          x.err = 1'b1;
          if (m_errcnt != 16'hFFFF) m_errcnt++;
          m_werr++;
        end
        if (m_werr == LOSS_THR) begin
          m_state = 0; m_fill = 0; m_match = 0; m_wbits = 0; m_werr = 0;
        end else if (m_wbits == LOSS_WIN) begin
          m_wbits = 0; m_werr = 0;
        end
      end else begin
        void'(ref_q.pop_front()); ref_q.push_back(d);
        if (m_state == 0) begin
          m_fill++;
          if (m_fill == 8) begin m_state = 1; m_match = 0; end
        end else begin
          any_one = 1'b0;
          foreach (ref_q[k]) if (ref_q[k]) any_one = 1'b1;
          if (d == pred && any_one) m_match++;
          else m_match = 0;
          if (m_match == LOCK_CNT) begin m_state = 2; m_wbits = 0; m_werr = 0; end
        end
      end
    end
    if (c) begin m_errcnt = 16'd0; m_bits = 32'd0; end
    x.locked  = (m_state == 2);
    x.err_cnt = m_errcnt;
    x.state   = 2'(m_state);
    x.bit_cnt = m_bits;
    exp_q.push_back(x);
  endtask

  // ---------------- driver / monitor ----------------
  task automatic drive(input bit e, input bit d, input bit c);
    @(negedge clk);
    en = e; din = d; clr = c;
    m_step(e, d, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("sb_locked", locked, x.locked);
        chk("sb_err", err, x.err);
        chk("sb_err_cnt", err_cnt, x.err_cnt);
        chk("sb_state", state, x.state);
`ifdef PRBS8_CHECKER_BITCNT_EN
        chk("sb_bit_cnt", bit_cnt_w, x.bit_cnt);
`endif
      end
    end
  end

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_bit_cnt"}, bit_cnt_w, 0);
    m_reset();
    exp_q.delete();
    en = 1'b0; din = 1'b0; clr = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  initial begin : main
    logic b;
    int   p[4];
    int   last;
    m_reset();
    #2;
    chk("por_locked", locked, 0);
    chk("por_state", state, 0);
    chk("por_err_cnt", err_cnt, 0);
    #10;
    rst = 1'b1;

    // Clean stream from seed A5: lock on the 24th bit.
    do_reset("rst_a");
    gen = 8'hA5;
    for (int i = 0; i < 1000; i++) begin
      get_bit(b);
      drive(1'b1, b, 1'b0);
      if (i == 7)  begin settle(); chk("a5_hunt_after_fill", state, 1); end
      if (i == 22) begin settle(); chk("a5_not_locked_23", locked, 0); end
      if (i == 23) begin settle(); chk("a5_locked_24", locked, 1); chk("a5_state_24", state, 2); end
    end
    settle();
    chk("a5_err_cnt_1000", err_cnt, 0);
`ifdef PRBS8_CHECKER_BITCNT_EN
    chk("a5_bit_cnt_976", bit_cnt_w, 976);
`endif

    // Single flipped bit at index 100: one pulse, flywheel holds lock.
    do_reset("rst_b");
    gen = 8'($urandom_range(1, 255));
    for (int i = 0; i < 200; i++) begin
      get_bit(b);
      drive(1'b1, b ^ (i == 100), 1'b0);
      if (i == 100) begin settle(); chk("flip1_err_pulse", err, 1); end
      if (i == 101) begin settle(); chk("flip1_err_drop", err, 0); end
    end
    settle();
    chk("flip1_err_cnt", err_cnt, 1);
    chk("flip1_locked", locked, 1);

    // Four errors within one window: drop to FILL, relock 24 bits later.
    do_reset("rst_c");
    gen  = 8'($urandom_range(1, 255));
    p[0] = 56 + $urandom_range(0, 15);
    for (int k = 1; k < 4; k++) p[k] = p[k-1] + $urandom_range(1, 5);
    last = p[3];
    for (int i = 0; i < last + 40; i++) begin
      get_bit(b);
      drive(1'b1, b ^ (i == p[0] || i == p[1] || i == p[2] || i == p[3]), 1'b0);
      if (i == p[2])     begin settle(); chk("loss_still_locked", locked, 1); end
      if (i == last)     begin settle(); chk("loss_state_fill", state, 0); chk("loss_unlocked", locked, 0); end
      if (i == last + 23) begin settle(); chk("relock_not_yet", locked, 0); end
      if (i == last + 24) begin settle(); chk("relock_24", locked, 1); end
    end
    settle();
    chk("loss_err_cnt", err_cnt, 4);

    // All-zero input never locks.
    do_reset("rst_d");
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 1'b0);
    settle();
    chk("zero_state_hunt", state, 1);
    chk("zero_locked", locked, 0);
    chk("zero_err_cnt", err_cnt, 0);

    // en toggled every cycle: 24 valid bits over 47 cycles.
    do_reset("rst_e");
    gen = 8'hA5;
    for (int c = 0; c < 47; c++) begin
      if (c % 2 == 0) begin get_bit(b); drive(1'b1, b, 1'b0); end
      else drive(1'b0, 1'(($urandom)), 1'b0);
      if (c == 45) begin settle(); chk("toggle_not_locked_46", locked, 0); end
      if (c == 46) begin settle(); chk("toggle_locked_47", locked, 1); end
    end

    // clr coincident with an error: count clears, pulse still fires.
    do_reset("rst_f");
    gen = 8'($urandom_range(1, 255));
    for (int i = 0; i < 170; i++) begin
      get_bit(b);
      drive(1'b1, b ^ (i == 40 || i == 80 || i == 120 || i == 160), (i == 160));
      if (i == 159) begin settle(); chk("clr_pre_err_cnt3", err_cnt, 3); end
      if (i == 160) begin settle(); chk("clr_err_cnt0", err_cnt, 0); chk("clr_err_pulse", err, 1); end
    end
    settle();
    chk("clr_still_locked", locked, 1);

    // Asynchronous reset mid-stream discards a non-zero err_cnt.
    do_reset("rst_g");
    gen = 8'($urandom_range(1, 255));
    for (int i = 0; i < 60; i++) begin
      get_bit(b);
      drive(1'b1, b ^ (i == 40), 1'b0);
    end
    settle();
    chk("mid_pre_err_cnt", err_cnt, 1);
    do_reset("mid_rst");

    // Randomised traffic: gaps, sparse errors, occasional clr.
    for (int r = 0; r < 3; r++) begin
      do_reset("rst_rand");
      gen = 8'($urandom_range(1, 255));
      for (int i = 0; i < 400; i++) begin
        if ($urandom % 4 != 0) begin
          get_bit(b);
          drive(1'b1, b ^ ($urandom % 40 == 0), ($urandom % 100 == 0));
        end else begin
          drive(1'b0, 1'(($urandom)), ($urandom % 100 == 0));
        end
      end
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) settle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
